// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: 2-entry skid buffer with a registered in_ready.
// Define EXMEM_FWD_EN to add the fwd_valid/fwd_rd/fwd_data forwarding outputs.
module ex_mem_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [DATA_W-1:0]     branch_target,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [DATA_W-1:0]     out_branch_target,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_mem_to_reg,
`ifdef EXMEM_FWD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
`endif
  output logic                  pc_src,
  output logic [DATA_W-1:0]     pc_target
);

  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     sd;
    logic [DATA_W-1:0]     tgt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
    logic                  mr;
    logic                  mw;
    logic                  m2r;
    logic                  tk;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t in_ent;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic push, pop;

  always_comb begin
    in_ent     = '0;
    in_ent.alu = alu_result;
    in_ent.sd  = store_data;
    in_ent.tgt = branch_target;
    in_ent.rd  = rd;
    in_ent.rw  = reg_write & (rd != '0);
    in_ent.mr  = mem_read;
    in_ent.mw  = mem_write;
    in_ent.m2r = mem_to_reg;
    in_ent.tk  = branch & alu_zero;
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (push) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end
    end else if (!skid_vld_q) begin
      if (push && pop) begin
        main_d = in_ent;
      end else if (push) begin
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end else if (pop) begin
        main_vld_d = 1'b0;
      end
    end else if (pop) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_alu_result    = main_q.alu;
  assign out_store_data    = main_q.sd;
  assign out_branch_target = main_q.tgt;
  assign out_rd            = main_q.rd;
  assign out_reg_write     = main_q.rw;
  assign out_mem_read      = main_q.mr;
  assign out_mem_write     = main_q.mw;
  assign out_mem_to_reg    = main_q.m2r;

  // Redirect only when MEM actually takes the branch; flush wins.
  assign pc_src    = pop & main_q.tk & ~flush;
  assign pc_target = main_q.tgt;

`ifdef EXMEM_FWD_EN
  assign fwd_valid = main_vld_q & main_q.rw & ~main_q.mr;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.alu;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe: directed scenarios plus a FIFO scoreboard.
// A negedge monitor pushes expected bundles on push and compares on pop.
module tb_ex_mem_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] store_data;
  logic [31:0] branch_target;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        branch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [31:0] out_branch_target;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic        pc_src;
  logic [31:0] pc_target;
`ifdef EXMEM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        tk;
  } exp_t;

  exp_t q[$];

  ex_mem_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_result(alu_result),
    .alu_zero(alu_zero),
    .store_data(store_data),
    .branch_target(branch_target),
    .rd(rd),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_to_reg(mem_to_reg),
    .branch(branch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_alu_result(out_alu_result),
    .out_store_data(out_store_data),
    .out_branch_target(out_branch_target),
    .out_rd(out_rd),
    .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg),
`ifdef EXMEM_FWD_EN
    .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd),
    .fwd_data(fwd_data),
`endif
    .pc_src(pc_src),
    .pc_target(pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue depth 2, flush empties it.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_pc;
    bit   do_push;
    if (!rst_n) begin
      q.delete();
    end else begin
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL mon_out_valid got=%b exp=%b",
                 out_valid, q.size() > 0);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL mon_in_ready got=%b exp=%b",
                 in_ready, q.size() < 2);
      end
      exp_pc = !flush && out_ready && q.size() > 0 && q[0].tk;
      checks++;
      if (pc_src !== exp_pc) begin
        failures++;
        $display("FAIL mon_pc_src got=%b exp=%b", pc_src, exp_pc);
      end
      if (flush) begin
        q.delete();
      end else begin
        do_push = in_valid && (q.size() < 2);
        if (out_ready && q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if ({out_alu_result, out_store_data, out_branch_target,
               out_rd, out_reg_write, out_mem_read, out_mem_write,
               out_mem_to_reg, pc_target} !==
              {e.alu, e.sd, e.tgt, e.rd, e.rw, e.mr, e.mw,
               e.m2r, e.tgt}) begin
            failures++;
            $display("FAIL mon_bundle got alu=%h sd=%h tgt=%h rd=%0d rw=%b mr=%b mw=%b m2r=%b pct=%h exp alu=%h sd=%h tgt=%h rd=%0d rw=%b mr=%b mw=%b m2r=%b",
                     out_alu_result, out_store_data, out_branch_target,
                     out_rd, out_reg_write, out_mem_read, out_mem_write,
                     out_mem_to_reg, pc_target, e.alu, e.sd, e.tgt,
                     e.rd, e.rw, e.mr, e.mw, e.m2r);
          end
        end
        if (do_push) begin
          e.alu = alu_result;
          e.sd  = store_data;
          e.tgt = branch_target;
          e.rd  = rd;
          e.rw  = reg_write && (rd != 5'd0);
          e.mr  = mem_read;
          e.mw  = mem_write;
          e.m2r = mem_to_reg;
          e.tk  = branch && alu_zero;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu,
                        input logic z, input logic [31:0] tgt,
                        input logic [4:0] r, input logic rw,
                        input logic mr, input logic br);
    in_valid      = v;
    alu_result    = alu;
    alu_zero      = z;
    store_data    = alu ^ 32'h5a5a_0000;
    branch_target = tgt;
    rd            = r;
    reg_write     = rw;
    mem_read      = mr;
    mem_write     = ~mr & alu[0];
    mem_to_reg    = mr;
    branch        = br;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({out_valid, in_ready, pc_src} !== 3'b010) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=010",
               {out_valid, in_ready, pc_src});
    end
    checks++;
    if ({out_alu_result, out_rd, out_reg_write, pc_target} !== '0) begin
      failures++;
      $display("FAIL reset_regs alu=%h rd=%0d rw=%b pct=%h exp=0",
               out_alu_result, out_rd, out_reg_write, pc_target);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_in(1'b1, 32'h10, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_alu_result, out_rd, out_reg_write, in_ready}
        !== {1'b1, 32'h10, 5'd5, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single v=%b alu=%h rd=%0d rw=%b rdy=%b exp 1 10 5 1 1",
               out_valid, out_alu_result, out_rd, out_reg_write, in_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(1'b1, 32'h1, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h2, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h3, 1'b0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got=%b exp=0", in_ready);
    end
    tick();
    tick();
    checks++;
    if ({in_ready, out_alu_result} !== {1'b0, 32'h1}) begin
      failures++;
      $display("FAIL bp_hold rdy=%b alu=%h exp 0 1", in_ready,
               out_alu_result);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_alu_result} !== {1'b1, 32'h2}) begin
      failures++;
      $display("FAIL bp_b v=%b alu=%h exp 1 2", out_valid, out_alu_result);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_alu_result} !== {1'b1, 32'h3}) begin
      failures++;
      $display("FAIL bp_c v=%b alu=%h exp 1 3", out_valid, out_alu_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_branch();
    out_ready = 1'b0;
    set_in(1'b1, 32'h0, 1'b1, 32'h80, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, pc_src} !== 2'b10) begin
        failures++;
        $display("FAIL br_stall%0d v=%b pc_src=%b exp 1 0", i,
                 out_valid, pc_src);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({pc_src, pc_target} !== {1'b1, 32'h80}) begin
      failures++;
      $display("FAIL br_take pc_src=%b pct=%h exp 1 80", pc_src, pc_target);
    end
    tick();
    checks++;
    if (pc_src !== 1'b0) begin
      failures++;
      $display("FAIL br_after got=%b exp=0", pc_src);
    end
    set_in(1'b1, 32'h4, 1'b0, 32'h90, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, pc_src, out_reg_write} !== 3'b100) begin
      failures++;
      $display("FAIL br_ntaken v/pc_src/rw=%b exp=100",
               {out_valid, pc_src, out_reg_write});
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_in(1'b1, 32'h11, 1'b1, 32'hc0, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'h22, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h33, 1'b0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, pc_src} !== 2'b00) begin
      failures++;
      $display("FAIL flush_cyc rdy/pc_src=%b exp=00", {in_ready, pc_src});
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL flush_after v/rdy=%b exp=01", {out_valid, in_ready});
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_quiet got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
             $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain left=%0d exp=0", q.size());
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h77, 1'b1, 32'h40, 5'd9, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, pc_src, out_alu_result} !==
        {3'b010, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset v/rdy/pc=%b alu=%h exp 010 0",
               {out_valid, in_ready, pc_src}, out_alu_result);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef EXMEM_FWD_EN
  task automatic test_fwd();
    out_ready = 1'b0;
    set_in(1'b1, 32'hdeadbeef, 1'b0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd7, 32'hdeadbeef}) begin
      failures++;
      $display("FAIL fwd_alu v=%b rd=%0d d=%h exp 1 7 deadbeef",
               fwd_valid, fwd_rd, fwd_data);
    end
    out_ready = 1'b1;
    set_in(1'b1, 32'hdeadbeef, 1'b0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, fwd_valid} !== 2'b10) begin
      failures++;
      $display("FAIL fwd_load v/fwd_valid=%b exp=10", {out_valid, fwd_valid});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_branch();
    test_flush();
`ifdef EXMEM_FWD_EN
    test_fwd();
`endif
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
